apb_master_bridge: RTL
======================

Name: apb_master_bridge

Overview:
- Requester end of the team's APB bus: converts a simple valid/ready command stream into APB SETUP/ACCESS transfers toward one peripheral.
- Drives the APB slave's psel/penable/pwrite/paddr/pwdata, waits on pready, and samples prdata/pslverr.
- Returns one response per command through a valid/ready response port.
- Sits between the control sequencer (or test host) and the APB slave peripheral registers.

Parameters:
- ADDR_W, 7, APB address width (paddr).
- DATA_W, 32, APB data width (pwdata/prdata).
- TIMEOUT_CYCLES, 16, max ACCESS cycles without pready before forced termination (used only with the optional feature).

Ports:
- pclk  in  1  APB clock; all logic on rising edge
- presetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  bridge accepts command this cycle
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_err  out  1  pslverr, or timeout when enabled
- psel  out  1  APB select
- penable  out  1  APB access phase
- pwrite  out  1  APB direction
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB slave ready
- pslverr  in  1  APB slave error

Behaviour:
- Reset (presetn low, asynchronous): state=IDLE. All outputs are 0: cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata.
- Reset mid-transfer aborts immediately. psel drops asynchronously and no response is produced.
- FSM states are IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- IDLE:
  - cmd_ready=1, psel=0, penable=0.
  - On cmd_valid&&cmd_ready, capture write/addr/wdata and go to SETUP.
  - pwdata = cmd_wdata on writes and 0 on reads.
- SETUP: psel=1, penable=0, exactly one cycle, then ACCESS.
- ACCESS:
  - psel=1, penable=1.
  - pwrite, paddr and pwdata are held stable from SETUP through the end of ACCESS.
  - When pready=1, sample prdata (reads only; writes return 0) and pslverr into rsp_rdata and rsp_err. Next state is RESP, with psel=0 and penable=0.
  - When pready=0, stay in ACCESS (wait state).
- pslverr and prdata are ignored whenever pready=0 or the state is not ACCESS.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err stay stable until rsp_valid&&rsp_ready.
  - Then return to IDLE, with rsp_valid=0 next cycle.
  - cmd_ready=0 while in RESP. Only one transfer is ever outstanding.
- After a transfer, paddr, pwrite and pwdata keep their last values; they are not cleared, to limit toggling.
- Latency with zero wait states:
  - Accept at cycle 0, SETUP at 1, ACCESS at 2, rsp_valid at 3.
  - Each pready=0 cycle in ACCESS adds one cycle.
- Throughput: at most one command per 4 cycles. The earliest next accept is the cycle after the response handshake.
- If rsp_ready is already 1 when RESP is entered, the handshake completes in that cycle and IDLE follows.
- A cmd_valid that arrives while busy is not accepted (cmd_ready=0). The requester must hold the command until it is accepted.

Optional Feature:
- Macro: APB_MASTER_BRIDGE_TIMEOUT_EN.
- With the macro:
  - A counter clears on SETUP and increments in each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYCLES, the transfer ends: psel=0, penable=0, go to RESP with rsp_err=1 and rsp_rdata=0.
  - A pready=1 in the same cycle as the count reaching TIMEOUT_CYCLES wins: normal completion.
- Without the macro: no counter is built, ACCESS waits for pready indefinitely, and rsp_err reflects pslverr only.

Decomposition:
- Shared package apb_pkg:
  - APB_ADDR_W=7 and APB_DATA_W=32 (parameter defaults come from these).
  - apb_master_state_e enum {IDLE, SETUP, ACCESS, RESP}.
- One optional sub-module apb_master_wdt: the timeout counter, instantiated only under APB_MASTER_BRIDGE_TIMEOUT_EN. Inputs are clear, count-enable and pready; output is the expired pulse.

Test Plan:
- Zero-wait write: cmd write addr=0x05, wdata=0xDEADBEEF, pready tied 1 -> psel at cycle 1; penable at cycle 2 with paddr=0x05 and pwdata=0xDEADBEEF stable; rsp_valid at cycle 3 with rsp_err=0 and rsp_rdata=0.
- Read with 3 wait states: addr=0x7F, pready low 3 ACCESS cycles then high with prdata=0x12345678 -> penable high 4 cycles, paddr stable throughout, rsp_rdata=0x12345678, rsp_valid at cycle 6.
- Slave error: write with pslverr=1 in the pready=1 cycle -> rsp_err=1. pslverr=1 during wait states (pready=0) must not affect rsp_err.
- Response backpressure: rsp_ready low 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable; cmd_ready=0 throughout; a new cmd_valid is accepted only the cycle after the handshake.
- Async reset in ACCESS: presetn low mid-wait -> psel, penable and all outputs 0 immediately; no rsp_valid after release; next command runs a normal SETUP/ACCESS.
- Timeout (macro defined, TIMEOUT_CYCLES=16): pready stuck 0 -> after 16 ACCESS cycles psel=0, rsp_valid=1, rsp_err=1, rsp_rdata=0. Without the macro, the bridge stays in ACCESS past 100 cycles.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: default bus widths and the requester FSM state encoding.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 7;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_master_state_e;

endpackage : apb_pkg

// File: rtl/apb_master_wdt.sv
// ACCESS-phase watchdog: counts wait-state cycles and flags the cycle in which
// the count would reach TIMEOUT_CYCLES while the slave is still not ready.
module apb_master_wdt #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic cnt_en_i,
    input  logic pready_i,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear on SETUP, bump on each unready ACCESS cycle, saturate at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (cnt_en_i && !pready_i && (cnt_q != CNT_W'(TIMEOUT_CYCLES))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Wait-state counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry fires in the cycle whose unready edge makes the count hit the limit.
    always_comb begin
        expired_c = cnt_en_i && !pready_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end

endmodule : apb_master_wdt

// File: rtl/apb_master_bridge.sv
// APB requester bridge: turns a valid/ready command stream into APB SETUP/ACCESS
// transfers and returns one response per command. Only one transfer is ever in flight.
// Optional ACCESS watchdog enabled by defining APB_MASTER_BRIDGE_TIMEOUT_EN.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W         = APB_ADDR_W,
    parameter int unsigned DATA_W         = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("apb_master_bridge: TIMEOUT_CYCLES must be at least 1");
    end

    apb_master_state_e state_q, state_d;

    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q,   rsp_err_d;
    logic              psel_q,      psel_d;
    logic              penable_q,   penable_d;
    logic              pwrite_q,    pwrite_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;

    logic              timeout_c;

`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
    logic wdt_clear_c;
    logic wdt_cnt_en_c;

    // Watchdog is armed in SETUP and counts only while the ACCESS phase is stalled.
    always_comb begin
        wdt_clear_c  = (state_q == SETUP);
        wdt_cnt_en_c = (state_q == ACCESS);
    end

    apb_master_wdt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdt (
        .clk       (pclk),
        .rst_n     (presetn),
        .clear_i   (wdt_clear_c),
        .cnt_en_i  (wdt_cnt_en_c),
        .pready_i  (pready),
        .expired_c (timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    // Next-state and next-output logic; every register holds unless a state says otherwise.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;

        unique case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                if (cmd_valid && cmd_ready_q) begin
                    state_d     = SETUP;
                    cmd_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    pwrite_d    = cmd_write;
                    paddr_d     = cmd_addr;
                    pwdata_d    = cmd_write ? cmd_wdata : '0;
                end
            end

            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end

            ACCESS: begin
                // A ready slave wins over a simultaneous watchdog expiry.
                if (pready) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pslverr;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                end else if (timeout_c) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b0;
                rsp_valid_d = 1'b0;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears every output and aborts any transfer.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;

endmodule : apb_master_bridge
